// File: rtl/mem_wb_stage_pkg.sv
// Shared writeback-source and load funct3 encodings for the MEM/WB stage.
package mem_wb_stage_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int INSTRET_W_DEF = 64;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_ALU2 = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// Combinational load-data formatter: picks the byte/halfword lane and extends it.
module mem_wb_stage_load_formatter
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (offset)
      2'd0: byte_lane = raw[7:0];
      2'd1: byte_lane = raw[15:8];
      2'd2: byte_lane = raw[23:16];
      2'd3: byte_lane = raw[31:24];
      default: byte_lane = raw[7:0];
    endcase
    // offset[0] is ignored for halfwords; misaligned accesses never reach here
    half_lane = offset[1] ? raw[31:16] : raw[15:0];

    result = raw;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH:   result = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_lane};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback source mux, register-file write port
// and retired-instruction counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int INSTRET_W = INSTRET_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 mem_reg_write,
  input  logic [4:0]           mem_rd,
  input  logic [1:0]           mem_wb_sel,
  input  logic [2:0]           mem_funct3,
  input  logic [XLEN-1:0]      mem_alu_result,
  input  logic [XLEN-1:0]      mem_load_data,
  input  logic [XLEN-1:0]      mem_pc_plus4,
  output logic [4:0]           writeReg,
  output logic                 regWriteEnable,
  output logic [XLEN-1:0]      writeData,
  output logic                 wb_valid,
  output logic [INSTRET_W-1:0] instret
);

  logic                 valid_q, valid_d;
  logic                 reg_write_q, reg_write_d;
  logic [4:0]           rd_q, rd_d;
  logic [1:0]           wb_sel_q, wb_sel_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [XLEN-1:0]      alu_result_q, alu_result_d;
  logic [XLEN-1:0]      load_data_q, load_data_d;
  logic [XLEN-1:0]      pc_plus4_q, pc_plus4_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]      load_fmt;

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    wb_sel_d     = wb_sel_q;
    funct3_d     = funct3_q;
    alu_result_d = alu_result_q;
    load_data_d  = load_data_q;
    pc_plus4_d   = pc_plus4_q;
    instret_d    = instret_q;
    // flush wins over stall so a bubble is inserted even while stalled
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (!stall) begin
      valid_d      = mem_valid;
      reg_write_d  = mem_reg_write;
      rd_d         = mem_rd;
      wb_sel_d     = mem_wb_sel;
      funct3_d     = mem_funct3;
      alu_result_d = mem_alu_result;
      load_data_d  = mem_load_data;
      pc_plus4_d   = mem_pc_plus4;
      if (mem_valid) instret_d = instret_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      wb_sel_q     <= '0;
      funct3_q     <= '0;
      alu_result_q <= '0;
      load_data_q  <= '0;
      pc_plus4_q   <= '0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      wb_sel_q     <= wb_sel_d;
      funct3_q     <= funct3_d;
      alu_result_q <= alu_result_d;
      load_data_q  <= load_data_d;
      pc_plus4_q   <= pc_plus4_d;
      instret_q    <= instret_d;
    end
  end

  mem_wb_stage_load_formatter #(.XLEN(XLEN)) u_load_formatter (
    .raw    (load_data_q),
    .offset (alu_result_q[1:0]),
    .funct3 (funct3_q),
    .result (load_fmt)
  );

  always_comb begin
    writeData = alu_result_q;
    case (wb_sel_q)
      WB_SEL_LOAD: writeData = load_fmt;
      WB_SEL_PC4:  writeData = pc_plus4_q;
      default:     writeData = alu_result_q;
    endcase
  end

  assign writeReg       = rd_q;
  assign regWriteEnable = valid_q & reg_write_q & (rd_q != 5'd0);
  assign wb_valid       = valid_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage: expectations queued at drive time,
// popped one cycle later and compared with immediate assertions.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4;
  logic [4:0]  writeReg;
  logic        regWriteEnable;
  logic [31:0] writeData;
  logic        wb_valid;
  logic [63:0] instret;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        valid;
    logic [63:0] instret;
    bit          full;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  logic [63:0] ei;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_pc_plus4   (mem_pc_plus4),
    .writeReg       (writeReg),
    .regWriteEnable (regWriteEnable),
    .writeData      (writeData),
    .wb_valid       (wb_valid),
    .instret        (instret)
  );

  task automatic push_exp(input string tag, input logic [4:0] rd, input logic we,
                          input logic [31:0] data, input logic valid, input bit full);
    exp_t e;
    e.tag = tag; e.rd = rd; e.we = we; e.data = data;
    e.valid = valid; e.instret = ei; e.full = full;
    sb.push_back(e);
    if (full) last = e;
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (wb_valid === e.valid) else begin
        failures++;
        $error("FAIL %s.wb_valid observed=%0b expected=%0b", e.tag, wb_valid, e.valid);
      end
      checks++;
      assert (regWriteEnable === e.we) else begin
        failures++;
        $error("FAIL %s.we observed=%0b expected=%0b", e.tag, regWriteEnable, e.we);
      end
      checks++;
      assert (instret === e.instret) else begin
        failures++;
        $error("FAIL %s.instret observed=%0h expected=%0h", e.tag, instret, e.instret);
      end
      if (e.full) begin
        checks++;
        assert (writeReg === e.rd) else begin
          failures++;
          $error("FAIL %s.writeReg observed=%0d expected=%0d", e.tag, writeReg, e.rd);
        end
        checks++;
        assert (writeData === e.data) else begin
          failures++;
          $error("FAIL %s.writeData observed=%08h expected=%08h", e.tag, writeData, e.data);
        end
      end
    end
  endtask

  // Drive one MEM-stage instruction with stall=flush=rst=0; exp is the hand-derived writeData.
  task automatic issue(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc4, input logic [31:0] exp_data);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld; mem_pc_plus4 = pc4;
    if (v) ei = ei + 64'd1;
    push_exp(tag, rd, v & rw & (rd != 5'd0), exp_data, v, 1'b1);
    tick_check();
  endtask

  localparam logic [31:0] RAW = 32'h80FF7F01;

  initial begin
    ei = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd7; mem_wb_sel = 2'b00;
    mem_funct3 = 3'b010; mem_alu_result = 32'h1234; mem_load_data = 32'h0;
    mem_pc_plus4 = 32'h0;

    push_exp("reset0", 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick_check();
    push_exp("reset1", 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick_check();

    issue("first",   1, 1, 5'd7, 2'b00, 3'b010, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234);
    issue("alu_rd5", 1, 1, 5'd5, 2'b00, 3'b010, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hDEAD_BEEF);
    issue("alu_rd0", 1, 1, 5'd0, 2'b00, 3'b010, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hDEAD_BEEF);
    issue("alu_sel3",1, 1, 5'd9, 2'b11, 3'b000, 32'h0000_5553, RAW,   32'h4, 32'h0000_5553);
    issue("no_rw",   1, 0, 5'd9, 2'b00, 3'b010, 32'h0000_0042, 32'h0, 32'h0, 32'h0000_0042);

    issue("lb_off3",  1, 1, 5'd10, 2'b01, 3'b000, 32'h0000_1003, RAW, 32'h0, 32'hFFFF_FF80);
    issue("lbu_off1", 1, 1, 5'd11, 2'b01, 3'b100, 32'h0000_1001, RAW, 32'h0, 32'h0000_007F);
    issue("lh_off2",  1, 1, 5'd12, 2'b01, 3'b001, 32'h0000_1002, RAW, 32'h0, 32'hFFFF_80FF);
    issue("lhu_off0", 1, 1, 5'd13, 2'b01, 3'b101, 32'h0000_1000, RAW, 32'h0, 32'h0000_7F01);
    issue("lw",       1, 1, 5'd14, 2'b01, 3'b010, 32'h0000_1000, RAW, 32'h0, RAW);
    issue("lb_off0",  1, 1, 5'd15, 2'b01, 3'b000, 32'h0000_1000, RAW, 32'h0, 32'h0000_0001);
    issue("lb_off2",  1, 1, 5'd16, 2'b01, 3'b000, 32'h0000_1002, RAW, 32'h0, 32'hFFFF_FFFF);
    issue("lbu_off2", 1, 1, 5'd17, 2'b01, 3'b100, 32'h0000_1002, RAW, 32'h0, 32'h0000_00FF);
    issue("lh_off3",  1, 1, 5'd18, 2'b01, 3'b001, 32'h0000_1003, RAW, 32'h0, 32'hFFFF_80FF);
    issue("lhu_off1", 1, 1, 5'd19, 2'b01, 3'b101, 32'h0000_1001, RAW, 32'h0, 32'h0000_7F01);
    issue("lh_off0",  1, 1, 5'd20, 2'b01, 3'b001, 32'h0000_1000, 32'h0000_8001, 32'h0, 32'hFFFF_8001);
    issue("f3_res3",  1, 1, 5'd21, 2'b01, 3'b011, 32'h0000_1003, RAW, 32'h0, RAW);
    issue("f3_res7",  1, 1, 5'd22, 2'b01, 3'b111, 32'h0000_1001, RAW, 32'h0, RAW);

    issue("jal", 1, 1, 5'd1, 2'b10, 3'b000, 32'h0000_2000, RAW, 32'h0000_0104, 32'h0000_0104);

    stall = 1'b1;
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd30; mem_wb_sel = 2'b00;
    mem_alu_result = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      push_exp("stall", last.rd, last.we, last.data, last.valid, 1'b1);
      tick_check();
    end

    flush = 1'b1;
    push_exp("flush_stall", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick_check();
    stall = 1'b0;
    push_exp("flush", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick_check();

    issue("bubble_in", 0, 1, 5'd6, 2'b00, 3'b010, 32'h0000_0777, 32'h0, 32'h0, 32'h0000_0777);
    issue("post_flush",1, 1, 5'd6, 2'b00, 3'b010, 32'h0000_0888, 32'h0, 32'h0, 32'h0000_0888);

    stall = 1'b1; flush = 1'b1; rst = 1'b1; mem_valid = 1'b1;
    ei = '0;
    push_exp("rst_mid_stall", 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick_check();

    rst = 1'b0; flush = 1'b0; stall = 1'b1; mem_valid = 1'b0;
    force dut.instret_d = 64'hFFFF_FFFF_FFFF_FFFF;
    ei = 64'hFFFF_FFFF_FFFF_FFFF;
    push_exp("preload", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick_check();
    release dut.instret_d;

    issue("wrap", 1, 1, 5'd3, 2'b00, 3'b010, 32'h0000_0ABC, 32'h0, 32'h0, 32'h0000_0ABC);
    checks++;
    assert (instret === 64'd0) else begin
      failures++;
      $error("FAIL wrap_zero observed=%0h expected=0", instret);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
